// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {WARMUP, RUN, HALT} ctrl_state_t;

  localparam int STAGE_IF   = 0;
  localparam int STAGE_DP   = 1;
  localparam int MAX_STAGES = 32;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } hs_t;

  // Index of the most significant set bit, with valid=0 for an all-zero vector.
  function automatic hs_t highest_set(input logic [MAX_STAGES-1:0] vec);
    hs_t r;
    r = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Saturating count of consecutive stalled cycles with a sticky timeout flag.
module stall_watchdog #(
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic stalled,
  output logic stall_timeout
);

  localparam int CW = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STALL_TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count holds while disabled so a halt does not reset the stall history.
  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      stall_timeout <= 1'b0;
    end else if (enable) begin
      if (stalled) begin
        if (count != LIMIT) count <= count + CW'(1);
        if (count == LIMIT) stall_timeout <= 1'b1;
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for an in-order pipeline: warm-up hold, backward
// stall propagation with bubble insertion, deferred redirect flushes, halt.
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_STAGES    = 5,
  parameter int WARMUP_CYCLES = 1,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_STAGES-1:0]         stall_req,
  input  logic                          flush_valid,
  input  logic [$clog2(NUM_STAGES)-1:0] flush_src,
  input  logic                          halt_req,
  output logic [NUM_STAGES-1:0]         stall,
  output logic [NUM_STAGES-1:0]         bubble,
  output logic [NUM_STAGES-1:0]         flush,
  output logic                          running,
  output logic                          stall_timeout
);

  localparam int SW = $clog2(NUM_STAGES);
  localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  ctrl_state_t   state;
  logic [WW-1:0] warm_cnt;
  logic          pend_valid;
  logic [SW-1:0] pend_src;

  hs_t           hs;
  logic          new_ok;
  logic          cand_valid;
  logic [SW-1:0] cand_src;
  logic          fire;

  function automatic logic older_stalled(input logic [NUM_STAGES-1:0] req,
                                         input logic [SW-1:0] src);
    logic r;
    r = 1'b0;
    for (int j = 0; j < NUM_STAGES; j++)
      if (j >= int'(src) && req[j]) r = 1'b1;
    return r;
  endfunction

  // The older (larger-index) redirect supersedes a younger one.
  always_comb begin
    hs         = highest_set(MAX_STAGES'(stall_req));
    new_ok     = flush_valid && (flush_src != '0) && (int'(flush_src) < NUM_STAGES);
    cand_valid = pend_valid || new_ok;
    cand_src   = pend_src;
    if (new_ok && (!pend_valid || flush_src > pend_src)) cand_src = flush_src;
    fire = (state == RUN) && !reset && cand_valid && !older_stalled(stall_req, cand_src);
  end

  always_comb begin
    stall  = '0;
    bubble = '0;
    flush  = '0;
    if (reset || state != RUN) begin
      stall = '1;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stall[i]  = hs.valid && (i <= int'(hs.idx));
        bubble[i] = hs.valid && (i == int'(hs.idx) + 1);
        if (fire && i < int'(cand_src)) begin
          flush[i]  = 1'b1;
          stall[i]  = 1'b0;
          bubble[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WARMUP;
      warm_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_src   <= '0;
    end else begin
      case (state)
        WARMUP: begin
          warm_cnt <= warm_cnt + WW'(1);
          if (warm_cnt == WW'(WARMUP_CYCLES - 1)) state <= RUN;
        end
        RUN: begin
          if (halt_req) state <= HALT;
          if (fire) begin
            pend_valid <= 1'b0;
          end else if (cand_valid) begin
            pend_valid <= 1'b1;
            pend_src   <= cand_src;
          end
        end
        HALT: begin
          if (!halt_req) state <= RUN;
          if (cand_valid) begin
            pend_valid <= 1'b1;
            pend_src   <= cand_src;
          end
        end
        default: state <= WARMUP;
      endcase
    end
  end

  assign running = (state == RUN);

  stall_watchdog #(.STALL_TIMEOUT(STALL_TIMEOUT)) u_watchdog (
    .clk           (clk),
    .reset         (reset),
    .enable        (state == RUN),
    .stalled       (|stall),
    .stall_timeout (stall_timeout)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: warm-up, stall/bubble, flush deferral,
// halt with a pending flush, watchdog and reset.
module tb_pipeline_controller;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] stall_req;
  logic         flush_valid;
  logic [2:0]   flush_src;
  logic         halt_req;
  logic [N-1:0] stall, bubble, flush;
  logic         running, stall_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_controller #(
    .NUM_STAGES(N), .WARMUP_CYCLES(3), .STALL_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .stall_req(stall_req), .flush_valid(flush_valid),
    .flush_src(flush_src), .halt_req(halt_req), .stall(stall), .bubble(bubble),
    .flush(flush), .running(running), .stall_timeout(stall_timeout)
  );

  // Drive one cycle's inputs at the falling edge, then settle before checking.
  task automatic step(input logic r, input logic [N-1:0] sr, input logic fv,
                      input logic [2:0] fs, input logic h);
    @(negedge clk);
    reset = r; stall_req = sr; flush_valid = fv; flush_src = fs; halt_req = h;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall_req = '0; flush_valid = 1'b0; flush_src = '0; halt_req = 1'b0;
    step(1, 5'b00000, 0, 0, 0);
    step(1, 5'b00000, 0, 0, 0);
    chk("rst_stall", 32'(stall), 32'h1f);
    chk("rst_bubble", 32'(bubble), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_timeout", 32'(stall_timeout), 32'h0);

    // warm-up: three held cycles, flush request ignored
    step(0, 5'b00000, 0, 0, 0);
    chk("warm0_stall", 32'(stall), 32'h1f);
    step(0, 5'b11111, 1, 2, 0);
    chk("warm1_flush", 32'(flush), 32'h0);
    chk("warm1_stall", 32'(stall), 32'h1f);
    step(0, 5'b00000, 0, 0, 1);
    chk("warm2_running", 32'(running), 32'h0);
    step(0, 5'b00000, 0, 0, 0);
    chk("run_running", 32'(running), 32'h1);
    chk("run_stall", 32'(stall), 32'h0);
    chk("run_no_pend", 32'(flush), 32'h0);

    // stall propagation
    step(0, 5'b00100, 0, 0, 0);
    chk("s2_stall", 32'(stall), 32'h07);
    chk("s2_bubble", 32'(bubble), 32'h08);
    chk("s2_flush", 32'(flush), 32'h0);
    step(0, 5'b10000, 0, 0, 0);
    chk("s4_stall", 32'(stall), 32'h1f);
    chk("s4_bubble", 32'(bubble), 32'h0);

    // immediate flush, then deferred flush
    step(0, 5'b00000, 1, 2, 0);
    chk("fl_now", 32'(flush), 32'h03);
    chk("fl_now_stall", 32'(stall), 32'h0);
    step(0, 5'b01000, 1, 2, 0);
    chk("fl_def0", 32'(flush), 32'h0);
    chk("fl_def0_stall", 32'(stall), 32'h0f);
    chk("fl_def0_bubble", 32'(bubble), 32'h10);
    step(0, 5'b01000, 0, 0, 0);
    chk("fl_def1", 32'(flush), 32'h0);
    step(0, 5'b00000, 0, 0, 0);
    chk("fl_release", 32'(flush), 32'h03);
    chk("fl_release_stall", 32'(stall), 32'h0);
    step(0, 5'b00000, 0, 0, 0);
    chk("fl_cleared", 32'(flush), 32'h0);

    // older redirect supersedes pending younger one
    step(0, 5'b10000, 1, 2, 0);
    chk("merge0", 32'(flush), 32'h0);
    step(0, 5'b10000, 1, 3, 0);
    chk("merge1", 32'(flush), 32'h0);
    step(0, 5'b00000, 0, 0, 0);
    chk("merge_fire", 32'(flush), 32'h07);
    step(0, 5'b00000, 0, 0, 0);
    chk("merge_once", 32'(flush), 32'h0);

    // out-of-range sources are dropped
    step(0, 5'b00000, 1, 0, 0);
    chk("src0", 32'(flush), 32'h0);
    step(0, 5'b00000, 1, 5, 0);
    chk("src5", 32'(flush), 32'h0);
    step(0, 5'b00000, 0, 0, 0);
    chk("src_not_latched", 32'(flush), 32'h0);

    // halt with a pending flush
    step(0, 5'b01000, 1, 2, 1);
    chk("halt_req_cycle", 32'(flush), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step(0, 5'b00000, 0, 0, 1);
      chk("halt_stall", 32'(stall), 32'h1f);
      chk("halt_running", 32'(running), 32'h0);
      chk("halt_flush", 32'(flush), 32'h0);
    end
    step(0, 5'b00000, 0, 0, 0);
    chk("halt_exit_stall", 32'(stall), 32'h1f);
    chk("halt_exit_flush", 32'(flush), 32'h0);
    step(0, 5'b00000, 0, 0, 0);
    chk("resume_running", 32'(running), 32'h1);
    chk("resume_flush", 32'(flush), 32'h03);

    // watchdog: 8 consecutive stalled cycles
    for (int c = 0; c < 8; c++) begin
      step(0, 5'b00010, 0, 0, 0);
      if (c == 0) begin
        chk("wd_stall", 32'(stall), 32'h03);
        chk("wd_bubble", 32'(bubble), 32'h04);
      end
    end
    chk("wd_before", 32'(stall_timeout), 32'h0);
    step(0, 5'b00000, 0, 0, 0);
    chk("wd_set", 32'(stall_timeout), 32'h1);
    step(0, 5'b10000, 1, 2, 0);
    chk("wd_sticky", 32'(stall_timeout), 32'h1);

    // reset with a pending flush
    step(1, 5'b00000, 0, 0, 0);
    chk("rst2_stall", 32'(stall), 32'h1f);
    chk("rst2_flush", 32'(flush), 32'h0);
    step(1, 5'b00000, 0, 0, 0);
    chk("rst2_timeout", 32'(stall_timeout), 32'h0);
    chk("rst2_running", 32'(running), 32'h0);
    for (int c = 0; c < 3; c++) step(0, 5'b00000, 0, 0, 0);
    chk("rst2_warm_last", 32'(running), 32'h0);
    step(0, 5'b00000, 0, 0, 0);
    chk("rst2_run", 32'(running), 32'h1);
    chk("rst2_pend_dropped", 32'(flush), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
